pwm_duty_modulator: RTL and testbench

- Consumes the 6-bit duty word produced by the triangle-wave duty generator and converts it into a pulse-width-modulated output pin.
- Free-running 64-step period counter advanced by a programmable prescaler.
- Duty word is double-buffered: sampled only at period boundaries, so each PWM period is glitch-free.
- Sits directly downstream of the duty generator and drives the board output (LED/driver).

---
 rtl/pwm_duty_modulator.sv | 100 ++++++++++
 tb/tb_pwm_duty_modulator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_modulator.sv
// PWM modulator: prescaled 64-step period counter compared against a period-buffered duty word.
// Define PWM_DEADTIME_EN to add a complementary output with dead-time on PWM_N_Out.
module pwm_duty_modulator #(
  parameter int PRESCALE_W = 8,
  parameter int DEADTIME   = 2
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic [5:0]            Duty_In,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  PWM_Out,
  output logic                  PWM_N_Out,
  output logic                  Period_Start,
  output logic [5:0]            Duty_Active
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [5:0]            per_cnt;
  logic                  en_q;
  logic                  tick, wrap, first;
  logic [5:0]            duty_eff;
  logic                  raw;

  assign tick  = (pre_cnt == Prescale);
  assign wrap  = tick && (per_cnt == 6'd63);
  assign first = Enable && !en_q;

  // The first enabled cycle compares against the incoming word, so the
  // opening period gets its full duty even though Duty_Active loads now.
  assign duty_eff = first ? Duty_In : Duty_Active;
  assign raw      = Enable && (per_cnt < duty_eff);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      en_q         <= 1'b0;
      pre_cnt      <= '0;
      per_cnt      <= '0;
      Duty_Active  <= '0;
      Period_Start <= 1'b0;
    end else begin
      en_q <= Enable;
      if (!Enable) begin
        pre_cnt      <= '0;
        per_cnt      <= '0;
        Duty_Active  <= '0;
        Period_Start <= 1'b0;
      end else begin
        pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) per_cnt <= per_cnt + 6'd1;
        if (first || wrap) Duty_Active <= Duty_In;
        Period_Start <= first || wrap;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

  logic            raw_n;
  logic [DT_W-1:0] dt_p, dt_n, dt_p_nx, dt_n_nx;

  assign raw_n = Enable && !(per_cnt < duty_eff);

  // dt_x reloads while output x is high and counts down once it falls; the
  // opposite output may rise only when the next value has reached zero.
  always_comb begin
    dt_p_nx = PWM_Out   ? DT_W'(DEADTIME) : ((dt_p != '0) ? dt_p - 1'b1 : dt_p);
    dt_n_nx = PWM_N_Out ? DT_W'(DEADTIME) : ((dt_n != '0) ? dt_n - 1'b1 : dt_n);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      dt_p      <= '0;
      dt_n      <= '0;
      PWM_Out   <= 1'b0;
      PWM_N_Out <= 1'b0;
    end else begin
      dt_p      <= dt_p_nx;
      dt_n      <= dt_n_nx;
      PWM_Out   <= raw   && !PWM_N_Out && (dt_n_nx == '0);
      PWM_N_Out <= raw_n && !PWM_Out   && (dt_p_nx == '0);
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^DEADTIME;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      PWM_Out   <= 1'b0;
      PWM_N_Out <= 1'b0;
    end else begin
      PWM_Out   <= raw;
      PWM_N_Out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_duty_modulator.sv
// Bench for pwm_duty_modulator: per-cycle expectations from a time-based period model,
// queued at drive time and compared one clock later, plus per-scenario aggregate counts.
module tb_pwm_duty_modulator;
  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       Enable = 1'b0;
  logic [5:0] Duty_In = '0;
  logic [7:0] Prescale = '0;
  logic       PWM_Out, PWM_N_Out, Period_Start;
  logic [5:0] Duty_Active;

  pwm_duty_modulator #(.PRESCALE_W(8), .DEADTIME(2)) dut (
    .sysclk(sysclk), .reset(reset), .Enable(Enable), .Duty_In(Duty_In),
    .Prescale(Prescale), .PWM_Out(PWM_Out), .PWM_N_Out(PWM_N_Out),
    .Period_Start(Period_Start), .Duty_Active(Duty_Active)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0, errors = 0;
  logic [7:0] expq[$];
  bit         en_prev = 1'b0;
  int         t = 0;
  logic [5:0] cur_duty = '0;
  int         hi_cnt = 0, ps_cnt = 0, ps_last = 0, nsteps = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: in enabled cycle t, step = (t/(P+1)) mod 64; duty latched at t=0
  // and at the last cycle of each period; results appear one clock later.
  task automatic step();
    int plen, per;
    logic pw, ps;
    logic [7:0] e, g;
    if (!Enable) begin
      e = '0;
      en_prev = 1'b0;
    end else begin
      if (!en_prev) begin
        t = 0;
        cur_duty = Duty_In;
      end
      plen = 64 * (int'(Prescale) + 1);
      per  = (t / (int'(Prescale) + 1)) % 64;
      pw   = (per < int'(cur_duty));
      ps   = (t == 0) || (t % plen == plen - 1);
      if (t % plen == plen - 1) cur_duty = Duty_In;
      e = {pw, ps, cur_duty};
      t++;
      en_prev = 1'b1;
    end
    expq.push_back(e);
    @(posedge sysclk); #1;
    g = expq.pop_front();
    nsteps++;
`ifdef PWM_DEADTIME_EN
    chk("ps_da", {25'd0, Period_Start, Duty_Active}, {25'd0, g[6:0]});
    chk("overlap", {31'd0, PWM_Out & PWM_N_Out}, 32'd0);
`else
    chk("out", {24'd0, PWM_Out, Period_Start, Duty_Active}, {24'd0, g});
    chk("pwm_n", {31'd0, PWM_N_Out}, 32'd0);
`endif
    hi_cnt += int'(PWM_Out);
    if (Period_Start) begin
      ps_cnt++;
      ps_last = nsteps;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_hi(input string tag, input int exp);
`ifndef PWM_DEADTIME_EN
    chk(tag, hi_cnt, exp);
`else
    chk(tag, {31'd0, hi_cnt > 0 || exp == 0}, 32'd1);
`endif
  endtask

  task automatic restart(input logic [5:0] d, input logic [7:0] p);
    Enable = 1'b0;
    step();
    Duty_In = d; Prescale = p; Enable = 1'b1;
    hi_cnt = 0; ps_cnt = 0; nsteps = 0;
  endtask

  initial begin
    #2;
    chk("rst_state", {16'd0, PWM_Out, PWM_N_Out, Period_Start, Duty_Active}, 32'd0);
    @(posedge sysclk); #1;
    reset = 1'b0;

    // Duty 0 over three periods
    restart(6'd0, 8'd0);
    run(192);
    chk_hi("d0_hi", 0);

    // Duty 63: low one step in each of three periods
    restart(6'd63, 8'd0);
    run(192);
    chk_hi("d63_hi", 189);
    chk("d63_ps", ps_cnt, 4);

    // Prescale 3: 256-clock period, 64 clocks high
    restart(6'd16, 8'd3);
    run(512);
    chk_hi("p3_hi", 128);
    chk("p3_ps", ps_cnt, 3);
    chk("p3_ps_last", ps_last, 512);

    // Double buffering: change at step 20 waits for the wrap
    restart(6'd10, 8'd0);
    run(20);
    Duty_In = 6'd50;
    run(43);
    chk("db_hold", {26'd0, Duty_Active}, 32'd10);
    chk_hi("db_hi10", 10);
    step();
    chk("db_load", {26'd0, Duty_Active}, 32'd50);
    hi_cnt = 0;
    run(64);
    chk_hi("db_hi50", 50);

    // Enable drop mid-period, then re-enable with a new duty
    run(30);
    Enable = 1'b0;
    step();
    chk("dis_pwm", {31'd0, PWM_Out}, 32'd0);
    chk("dis_da", {26'd0, Duty_Active}, 32'd0);
    Duty_In = 6'd20; Enable = 1'b1; hi_cnt = 0;
    step();
    chk("reen_da", {26'd0, Duty_Active}, 32'd20);
    run(63);
    chk_hi("reen_hi", 20);

    // Async reset mid-period, then first-period timing after release
    restart(6'd40, 8'd0);
    run(100);
    #2;
    reset = 1'b1;
    #1;
    chk("arst", {16'd0, PWM_Out, PWM_N_Out, Period_Start, Duty_Active}, 32'd0);
    repeat (3) @(posedge sysclk);
    #1;
    chk("arst_hold", {16'd0, PWM_Out, PWM_N_Out, Period_Start, Duty_Active}, 32'd0);
    reset = 1'b0;
    en_prev = 1'b0;
    hi_cnt = 0; ps_cnt = 0; nsteps = 0;
    run(64);
    chk("rel_ps", ps_cnt, 2);
    chk("rel_ps_at", ps_last, 64);
    chk_hi("rel_hi", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
